lsu_mem_access: RTL and testbench

//  Memory-access stage between the EXU->LSU pipeline register and the LSU->WBU register of the backend.

---
 rtl/lsu_mem_access_pkg.sv | 38 +++
 rtl/lsu_data_align.sv | 56 +++++
 rtl/lsu_mem_access.sv | 222 ++++++++++++++++++++++
 tb/tb_lsu_mem_access.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_access_pkg.sv
// Shared types and constants for the LSU memory-access stage.
//   mem_size_t          : access width encoding carried on req_size
//   LSU_TIMEOUT_DEFAULT : default bus wait limit in cycles
//   decode_size()       : maps the raw 2-bit size field (3 behaves as word)
//   is_misaligned()     : natural-alignment test for a size/offset pair
package lsu_mem_access_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    localparam int LSU_TIMEOUT_DEFAULT = 256;

    // The reserved encoding 3 is folded onto word so downstream logic only
    // ever sees the three legal enum values.
    function automatic mem_size_t decode_size(input logic [1:0] raw);
        mem_size_t sz;
        case (raw)
            2'd0:    sz = MEM_BYTE;
            2'd1:    sz = MEM_HALF;
            default: sz = MEM_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input mem_size_t sz, input logic [1:0] a);
        logic mis;
        case (sz)
            MEM_HALF: mis = a[0];
            MEM_WORD: mis = (a != 2'b00);
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering for the LSU.
//   size        in  access width
//   addr_lo     in  byte offset within the word
//   st_data     in  LSB-aligned store data
//   rd_word     in  raw bus read word
//   ld_unsigned in  1 = zero-extend, 0 = sign-extend
//   be          out byte enables for the access
//   st_word     out store data replicated across all lanes
//   ld_value    out extracted and extended load result
module lsu_data_align
    import lsu_mem_access_pkg::*;
(
    input  mem_size_t   size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] rd_word,
    input  logic        ld_unsigned,
    output logic [3:0]  be,
    output logic [31:0] st_word,
    output logic [31:0] ld_value
);

    logic [31:0] shifted;

    always_comb begin
        be = 4'b1111;
        case (size)
            MEM_BYTE: be = 4'b0001 << addr_lo;
            MEM_HALF: be = 4'b0011 << addr_lo;
            default:  be = 4'b1111;
        endcase
    end

    // Replicating the data into every lane lets the bus slave pick the
    // bytes it needs using be alone, independent of the address offset.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign st_word[8*gi +: 8] = (size == MEM_BYTE) ? st_data[7:0] :
                                        (size == MEM_HALF) ? st_data[8*(gi%2) +: 8] :
                                                             st_data[8*gi +: 8];
        end
    endgenerate

    assign shifted = rd_word >> {addr_lo, 3'b000};

    always_comb begin
        ld_value = shifted;
        case (size)
            MEM_BYTE: ld_value = {{24{~ld_unsigned & shifted[7]}},  shifted[7:0]};
            MEM_HALF: ld_value = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
            default:  ld_value = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_access.sv
// LSU memory-access stage: converts the registered load/store request into
// one bus transaction and reports the result or fault to writeback.
//   clk, rst           clock, synchronous active-high reset
//   req_*              registered request from EXU (held while lsu_busy)
//   exc_in, flush      suppress a new access / abandon results
//   bus_*              single-outstanding request/ack bus
//   lsu_busy           freezes the upstream pipeline register
//   load_data(_valid)  load result and its one-cycle strobe
//   misalign_ld/st     one-cycle misalignment pulses (no bus access)
//   access_fault       one-cycle pulse on bus error or timeout
module lsu_mem_access
    import lsu_mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic        exc_in,
    input  logic        flush,
    output logic        bus_req_valid,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata,
    output logic        lsu_busy,
    output logic [31:0] load_data,
    output logic        load_data_valid,
    output logic        misalign_ld,
    output logic        misalign_st,
    output logic        access_fault
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    lsu_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    mem_size_t   size_q, size_d;
    logic        uns_q, uns_d;
    logic        flushed_q, flushed_d;
    logic        fault_q, fault_d;
    logic        ld_ok_q, ld_ok_d;
    logic [31:0] load_data_q, load_data_d;

    logic        is_load, is_store, start, misaligned;
    mem_size_t   req_sz, al_size;
    logic [1:0]  al_addr_lo;
    logic        al_uns;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_load;

    // Load wins when both op bits are set.
    assign is_load    = req_load;
    assign is_store   = req_store & ~req_load;
    assign start      = (req_load | req_store) & ~exc_in & ~flush;
    assign req_sz     = decode_size(req_size);
    assign misaligned = is_misaligned(req_sz, req_addr[1:0]);

    // One aligner serves both directions: in IDLE it shapes the incoming
    // store, afterwards it extracts the load using the captured attributes.
    assign al_size    = (state_q == ST_IDLE) ? req_sz        : size_q;
    assign al_addr_lo = (state_q == ST_IDLE) ? req_addr[1:0] : addr_q[1:0];
    assign al_uns     = (state_q == ST_IDLE) ? req_unsigned  : uns_q;

    lsu_data_align u_align (
        .size        (al_size),
        .addr_lo     (al_addr_lo),
        .st_data     (req_wdata),
        .rd_word     (bus_rdata),
        .ld_unsigned (al_uns),
        .be          (al_be),
        .st_word     (al_wdata),
        .ld_value    (al_load)
    );

    assign load_data = load_data_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        addr_d          = addr_q;
        be_d            = be_q;
        wdata_d         = wdata_q;
        we_d            = we_q;
        size_d          = size_q;
        uns_d           = uns_q;
        flushed_d       = flushed_q;
        fault_d         = fault_q;
        ld_ok_d         = ld_ok_q;
        load_data_d     = load_data_q;
        bus_req_valid   = 1'b0;
        bus_addr        = 32'h0;
        bus_we          = 1'b0;
        bus_be          = 4'h0;
        bus_wdata       = 32'h0;
        lsu_busy        = 1'b0;
        load_data_valid = 1'b0;
        misalign_ld     = 1'b0;
        misalign_st     = 1'b0;
        access_fault    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (misaligned) begin
                        misalign_ld = is_load;
                        misalign_st = is_store;
                    end else begin
                        lsu_busy  = 1'b1;
                        addr_d    = req_addr;
                        be_d      = al_be;
                        wdata_d   = al_wdata;
                        we_d      = is_store;
                        size_d    = req_sz;
                        uns_d     = req_unsigned;
                        cnt_d     = '0;
                        flushed_d = 1'b0;
                        fault_d   = 1'b0;
                        ld_ok_d   = 1'b0;
                        state_d   = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                bus_req_valid = 1'b1;
                bus_addr      = {addr_q[31:2], 2'b00};
                bus_we        = we_q;
                bus_be        = be_q;
                bus_wdata     = wdata_q;
                lsu_busy      = 1'b1;
                // A flush cannot retract the request; remember it and discard
                // the outcome once the handshake closes.
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (bus_ack) begin
                    if (flushed_q | flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                        fault_d = bus_err;
                        ld_ok_d = ~we_q & ~bus_err;
                        if (~we_q & ~bus_err) begin
                            load_data_d = al_load;
                        end
                    end
                end else if (cnt_q == CNT_LAST) begin
                    if (flushed_q | flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                        fault_d = 1'b1;
                        ld_ok_d = 1'b0;
                    end
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d         = ST_IDLE;
                load_data_valid = ld_ok_q & ~flush;
                access_fault    = fault_q & ~flush;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= 32'h0;
            be_q        <= 4'h0;
            wdata_q     <= 32'h0;
            we_q        <= 1'b0;
            size_q      <= MEM_BYTE;
            uns_q       <= 1'b0;
            flushed_q   <= 1'b0;
            fault_q     <= 1'b0;
            ld_ok_q     <= 1'b0;
            load_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            flushed_q   <= flushed_d;
            fault_q     <= fault_d;
            ld_ok_q     <= ld_ok_d;
            load_data_q <= load_data_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Self-checking bench for lsu_mem_access: directed scenarios followed by
// randomized transactions, checked against an arithmetic reference model.
module tb_lsu_mem_access;

    localparam int TO = 256;

    logic        clk;
    logic        rst;
    logic        req_load, req_store, req_unsigned, exc_in, flush;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        bus_req_valid, bus_we, bus_ack, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        lsu_busy, load_data_valid, misalign_ld, misalign_st, access_fault;
    logic [31:0] load_data;

    int checks = 0;
    int errors = 0;

    lsu_mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_load        (req_load),
        .req_store       (req_store),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .exc_in          (exc_in),
        .flush           (flush),
        .bus_req_valid   (bus_req_valid),
        .bus_addr        (bus_addr),
        .bus_we          (bus_we),
        .bus_be          (bus_be),
        .bus_wdata       (bus_wdata),
        .bus_ack         (bus_ack),
        .bus_err         (bus_err),
        .bus_rdata       (bus_rdata),
        .lsu_busy        (lsu_busy),
        .load_data       (load_data),
        .load_data_valid (load_data_valid),
        .misalign_ld     (misalign_ld),
        .misalign_st     (misalign_st),
        .access_fault    (access_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic mdl_mis(input logic [1:0] sz, input logic [1:0] a);
        return (int'(a) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] mdl_be(input logic [1:0] sz, input logic [1:0] a);
        int n;
        n = nbytes(sz);
        return 4'(((1 << n) - 1) << int'(a));
    endfunction

    function automatic logic [31:0] mdl_wd(input logic [31:0] d, input logic [1:0] sz);
        int n;
        n = nbytes(sz);
        if (n == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (n == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] mdl_ld(input logic [31:0] rd, input logic [1:0] sz,
                                           input logic [1:0] a, input logic uns);
        int n;
        logic [31:0] sh, mask, v;
        n    = nbytes(sz);
        sh   = rd >> (8 * int'(a));
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
        v    = sh & mask;
        if (!uns && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // One full request: start cycle, dly+1 WAIT cycles, DONE, back to IDLE.
    task automatic run_access(input logic ld, input logic st, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                              input int dly, input logic [31:0] rd, input logic err);
        logic mis, is_ld, we;
        is_ld = ld;
        we    = st & ~ld;
        mis   = mdl_mis(sz, addr[1:0]);
        req_load = ld; req_store = st; req_addr = addr; req_wdata = wd;
        req_size = sz; req_unsigned = uns;
        settle();
        if (mis) begin
            chk("mis_ld", misalign_ld, is_ld);
            chk("mis_st", misalign_st, we);
            chk("mis_busy", lsu_busy, 0);
            chk("mis_valid", bus_req_valid, 0);
            tick();
            req_load = 0; req_store = 0;
            settle();
            chk("mis_after_valid", bus_req_valid, 0);
            chk("mis_after_pulse", misalign_ld | misalign_st | load_data_valid | access_fault, 0);
            $display("txn ld=%0d st=%0d addr=%h size=%0d misaligned", ld, st, addr, sz);
            return;
        end
        chk("start_busy", lsu_busy, 1);
        chk("start_valid", bus_req_valid, 0);
        for (int k = 0; k <= dly; k++) begin
            tick();
            if (k == dly) begin
                bus_ack = 1; bus_err = err; bus_rdata = rd;
            end else begin
                bus_rdata = $urandom;
            end
            settle();
            chk("wait_valid", bus_req_valid, 1);
            chk("wait_busy", lsu_busy, 1);
            chk("wait_addr", bus_addr, {addr[31:2], 2'b00});
            chk("wait_be", bus_be, mdl_be(sz, addr[1:0]));
            chk("wait_we", bus_we, we);
            chk("wait_wdata", bus_wdata, mdl_wd(wd, sz));
            chk("wait_pulses", load_data_valid | access_fault, 0);
        end
        tick();
        bus_ack = 0; bus_err = 0; req_load = 0; req_store = 0;
        settle();
        chk("done_busy", lsu_busy, 0);
        chk("done_valid", bus_req_valid, 0);
        chk("done_ldv", load_data_valid, is_ld & ~err);
        chk("done_fault", access_fault, err);
        if (is_ld && !err) chk("done_data", load_data, mdl_ld(rd, sz, addr[1:0], uns));
        tick();
        settle();
        chk("idle_pulses", load_data_valid | access_fault, 0);
        chk("idle_busy", lsu_busy, 0);
        $display("txn ld=%0d st=%0d addr=%h size=%0d uns=%0d dly=%0d err=%0d rdata=%h load_data=%h",
                 ld, st, addr, sz, uns, dly, err, rd, load_data);
    endtask

    initial begin
        int n;
        logic [1:0] sz;
        logic [31:0] a;
        int op;

        rst = 1; req_load = 0; req_store = 0; req_addr = 0; req_wdata = 0;
        req_size = 0; req_unsigned = 0; exc_in = 0; flush = 0;
        bus_ack = 0; bus_err = 0; bus_rdata = 0;
        tick(); tick();
        chk("rst_valid", bus_req_valid, 0);
        chk("rst_busy", lsu_busy, 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_pulses", {load_data_valid, misalign_ld, misalign_st, access_fault}, 0);
        chk("rst_bus", bus_addr | bus_wdata | {28'h0, bus_be} | {31'h0, bus_we}, 0);
        rst = 0;
        tick();

        // 1. LW, ack 3 cycles after valid
        run_access(1, 0, 32'h0000_1000, 32'h0, 2'd2, 0, 3, 32'hDEAD_BEEF, 0);
        chk("lw_const", load_data, 32'hDEAD_BEEF);
        // 2. LB / LBU at offset 3
        run_access(1, 0, 32'h0000_1003, 32'h0, 2'd0, 0, 0, 32'h8012_3456, 0);
        chk("lb_const", load_data, 32'hFFFF_FF80);
        run_access(1, 0, 32'h0000_1003, 32'h0, 2'd0, 1, 0, 32'h8012_3456, 0);
        chk("lbu_const", load_data, 32'h0000_0080);
        // 3. SH at 0x102
        run_access(0, 1, 32'h0000_0102, 32'h1234_ABCD, 2'd1, 0, 1, 32'h0, 0);
        // 4. misaligned LW
        run_access(1, 0, 32'h0000_1001, 32'h0, 2'd2, 0, 0, 32'h0, 0);
        // misaligned SH
        run_access(0, 1, 32'h0000_2001, 32'h5555_AAAA, 2'd1, 0, 0, 32'h0, 0);
        // 5b. bus error on load
        run_access(1, 0, 32'h0000_4000, 32'h0, 2'd2, 0, 2, 32'h1111_1111, 1);

        // 5a. timeout
        req_load = 1; req_addr = 32'h0000_3000; req_size = 2'd2;
        settle();
        n = 0;
        tick();
        settle();
        while (bus_req_valid === 1'b1 && n < 400) begin
            n++;
            tick();
            settle();
        end
        req_load = 0;
        chk("timeout_cycles", n, TO);
        chk("timeout_fault", access_fault, 1);
        chk("timeout_ldv", load_data_valid, 0);
        tick(); settle();
        chk("timeout_after", access_fault, 0);
        $display("txn timeout wait_cycles=%0d", n);

        // 6a. flush in 2nd WAIT cycle, ack two cycles later
        req_load = 1; req_addr = 32'h0000_2000; req_size = 2'd2;
        tick(); settle();
        chk("fl_w1_valid", bus_req_valid, 1);
        tick();
        flush = 1; req_load = 0;
        settle();
        chk("fl_w2_valid", bus_req_valid, 1);
        tick();
        flush = 0;
        settle();
        chk("fl_w3_valid", bus_req_valid, 1);
        chk("fl_w3_addr", bus_addr, 32'h0000_2000);
        tick();
        bus_ack = 1; bus_rdata = 32'hCAFE_F00D;
        settle();
        chk("fl_w4_valid", bus_req_valid, 1);
        tick();
        bus_ack = 0;
        settle();
        chk("fl_idle_valid", bus_req_valid, 0);
        chk("fl_idle_busy", lsu_busy, 0);
        chk("fl_idle_pulses", load_data_valid | access_fault, 0);
        tick(); settle();
        chk("fl_late_pulses", load_data_valid | access_fault, 0);
        $display("txn flush_in_wait");

        // flush during DONE suppresses the result pulse
        req_load = 1; req_addr = 32'h0000_0040; req_size = 2'd2;
        tick();
        bus_ack = 1; bus_rdata = 32'h0BAD_0BAD;
        tick();
        bus_ack = 0; flush = 1; req_load = 0;
        settle();
        chk("fl_done_pulses", load_data_valid | access_fault, 0);
        chk("fl_done_busy", lsu_busy, 0);
        tick();
        flush = 0;
        $display("txn flush_in_done");

        // 6b. reset mid-WAIT
        req_store = 1; req_addr = 32'h0000_0800; req_wdata = 32'h1357_9BDF; req_size = 2'd2;
        tick(); settle();
        chk("rstw_valid_before", bus_req_valid, 1);
        rst = 1; req_store = 0;
        tick(); settle();
        chk("rstw_valid", bus_req_valid, 0);
        chk("rstw_busy", lsu_busy, 0);
        chk("rstw_bus", bus_addr | bus_wdata | {28'h0, bus_be} | {31'h0, bus_we}, 0);
        chk("rstw_out", load_data | {28'h0, load_data_valid, misalign_ld, misalign_st, access_fault}, 0);
        rst = 0;
        tick();
        $display("txn reset_in_wait");

        // upstream exception suppresses the access
        req_load = 1; exc_in = 1; req_addr = 32'h0000_0010; req_size = 2'd2;
        settle();
        chk("exc_busy", lsu_busy, 0);
        tick(); settle();
        chk("exc_valid", bus_req_valid, 0);
        req_load = 0; exc_in = 0;

        // stray ack while idle
        bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
        tick();
        bus_ack = 0;
        settle();
        chk("stray_ack", load_data_valid | access_fault | bus_req_valid, 0);
        tick();
        $display("txn exc_and_stray_ack");

        // randomized transactions
        for (int i = 0; i < 40; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = a[1:0] & ~2'(nbytes(sz) - 1);
            op = $urandom_range(0, 2);
            run_access(op != 1, op != 0, a, $urandom, sz, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 4), $urandom, $urandom_range(0, 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
